// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the two requester ports, the acknowledge/read-data return path
//   and the RAM command port of mem_arbiter.
//   slave  : arbiter view (requests and mem_rdata in, acks/rdata/mem_* out)
//   master : environment view (requesters plus RAM)
// Signals:
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1 : per-master request
//   ack0/ack1, rdata : one-cycle completion pulse and returned read data
//   busy             : arbiter is in ACCESS or DONE
//   mem_cmd/mem_addr/mem_wdata/mem_rdata : RAM port (00 none, 01 read, 11 write)
interface mem_arbiter_if #(
  parameter int AW = 9,
  parameter int DW = 16
);
  logic          req0, req1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata;
  logic          busy;
  logic [1:0]    mem_cmd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata, busy, mem_cmd, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata, busy, mem_cmd, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Serialises two masters (port 0 = CPU, port 1 = DMA/debug) onto a single
//   read/write RAM port. Three-state sequence IDLE -> ACCESS -> DONE, one
//   access per three cycles, round-robin between contending masters.
// Ports:
//   clk   : clock, all state changes on rising edge
//   reset : synchronous, active-high; abandons any transfer in flight
//   bus   : mem_arbiter_if.slave (requests, acks, rdata, busy, RAM port)

// Per-master slice: eligibility and the registered acknowledge pulse.
module mem_arbiter_port (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic ack_set,
  output logic elig,
  output logic ack
);
  // A master whose ack is still high is masked so a held req is not
  // served twice; the other master may still win that cycle.
  assign elig = req & ~ack;

  always_ff @(posedge clk) begin
    if (reset) ack <= 1'b0;
    else       ack <= ack_set;
  end
endmodule

module mem_arbiter #(
  parameter int AW = 9,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);
  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b11;
  localparam int NP = 2;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state, state_nx;
  logic [NP-1:0] req_v, elig, ack_q, ack_set;
  logic          grant, win_nx;
  logic          win_id, lat_we, last;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata, rdata_q;
  logic [1:0]    cmd;

  assign req_v   = {bus.req1, bus.req0};
  assign ack_set = {(state == DONE) &  win_id,
                    (state == DONE) & ~win_id};

  for (genvar i = 0; i < NP; i++) begin : g_port
    mem_arbiter_port u_port (
      .clk     (clk),
      .reset   (reset),
      .req     (req_v[i]),
      .ack_set (ack_set[i]),
      .elig    (elig[i]),
      .ack     (ack_q[i])
    );
  end

  // Next state, grant decision and RAM command.
  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    win_nx   = win_id;
    cmd      = MNONE;
    case (state)
      IDLE: begin
        if (|elig) begin
          grant    = 1'b1;
          state_nx = ACCESS;
          // On contention the master not served last wins.
          win_nx   = (&elig) ? ~last : elig[1];
        end
      end
      ACCESS: begin
        cmd      = lat_we ? MWRITE : MREAD;
        state_nx = DONE;
      end
      DONE: begin
        // Reads keep MREAD up so the RAM data stays valid for capture.
        cmd      = lat_we ? MNONE : MREAD;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Request latches, round-robin pointer and read data return.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_id    <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      last      <= 1'b1;  // port 0 wins the first contention
    end else begin
      if (grant) begin
        win_id    <= win_nx;
        lat_we    <= win_nx ? bus.we1    : bus.we0;
        lat_addr  <= win_nx ? bus.addr1  : bus.addr0;
        lat_wdata <= win_nx ? bus.wdata1 : bus.wdata0;
      end
      if (state == DONE) begin
        last <= win_id;
        if (!lat_we) rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.ack0      = ack_q[0];
  assign bus.ack1      = ack_q[1];
  assign bus.rdata     = rdata_q;
  assign bus.busy      = (state != IDLE);
  assign bus.mem_cmd   = cmd;
  assign bus.mem_addr  = lat_addr;
  assign bus.mem_wdata = lat_wdata;

  a_ack_onehot: assert property (@(posedge clk) disable iff (reset)
    !(ack_q[0] && ack_q[1]));
  a_write_single: assert property (@(posedge clk) disable iff (reset)
    (cmd == MWRITE) |=> (cmd != MWRITE));
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Scoreboard bench for mem_arbiter: expected acks (read data or "rdata
//   unchanged") are queued per port when a request is driven and popped
//   when the corresponding ack appears. Cycle-exact checks cover latency,
//   command timing, masking, round-robin and reset abandonment.
module tb_mem_arbiter;
  localparam int AW = 9;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  mem_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

  // RAM model: writes on MWRITE, registered read of the presented address.
  logic [DW-1:0] ram     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.mem_cmd == 2'b11) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  typedef struct packed { logic we; logic [DW-1:0] data; } exp_t;
  exp_t q0[$], q1[$];
  exp_t mon_e;
  int vecs = 0, errs = 0;
  logic [DW-1:0] last_rd = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic push_exp(input int p, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    exp_t e;
    e.we   = we;
    e.data = we ? d : ref_mem[a];
    if (we) ref_mem[a] = d;
    if (p == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic issue(input int p, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    if (p == 0) begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end
    push_exp(p, we, a, d);
  endtask

  // Scoreboard side: every ack must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.ack0 || bus.ack1) chk("ack_onehot", {31'd0, bus.ack0 & bus.ack1}, 32'd0);
    if (bus.ack0) begin
      if (q0.size() == 0) chk("ack0_spurious", 32'd1, 32'd0);
      else begin
        mon_e = q0.pop_front();
        chk("rdata_p0", bus.rdata, mon_e.we ? last_rd : mon_e.data);
        if (!mon_e.we) last_rd = mon_e.data;
      end
    end
    if (bus.ack1) begin
      if (q1.size() == 0) chk("ack1_spurious", 32'd1, 32'd0);
      else begin
        mon_e = q1.pop_front();
        chk("rdata_p1", bus.rdata, mon_e.we ? last_rd : mon_e.data);
        if (!mon_e.we) last_rd = mon_e.data;
      end
    end
  end

  task automatic do_reset;
    reset = 1'b1; last_rd = '0;
    tick; tick;
    reset = 1'b0;
    tick;
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) begin
      ram[i]     = DW'(i * 16'h0101) ^ 16'h5A5A;
      ref_mem[i] = DW'(i * 16'h0101) ^ 16'h5A5A;
    end
    ram[5] = 16'h1234; ref_mem[5] = 16'h1234;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;

    // Reset values
    reset = 1'b1;
    tick; tick;
    chk("rst_cmd",   bus.mem_cmd,   0);
    chk("rst_addr",  bus.mem_addr,  0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_rdata", bus.rdata,     0);
    chk("rst_ack",   {bus.ack1, bus.ack0}, 0);
    chk("rst_busy",  bus.busy,      0);
    reset = 1'b0;
    tick;

    // Single read by port 0
    issue(0, 1'b0, 9'h005, '0);
    chk("t1_c0_cmd", bus.mem_cmd, 2'b00);
    tick; chk("t1_c1_cmd", bus.mem_cmd, 2'b01); chk("t1_c1_addr", bus.mem_addr, 9'h005);
    tick; chk("t1_c2_cmd", bus.mem_cmd, 2'b01); chk("t1_c2_busy", bus.busy, 1);
    tick; chk("t1_c3_ack0", bus.ack0, 1); chk("t1_c3_ack1", bus.ack1, 0);
    chk("t1_c3_rdata", bus.rdata, 16'h1234); chk("t1_c3_cmd", bus.mem_cmd, 2'b00);
    bus.req0 = 0;
    tick; chk("t1_c4_ack0", bus.ack0, 0);

    // Single write by port 1, then read back by port 0
    issue(1, 1'b1, 9'h01A, 16'hBEEF);
    tick; chk("t2_c1_cmd", bus.mem_cmd, 2'b11); chk("t2_c1_wdata", bus.mem_wdata, 16'hBEEF);
    tick; chk("t2_c2_cmd", bus.mem_cmd, 2'b00); chk("t2_c2_busy", bus.busy, 1);
    tick; chk("t2_c3_ack1", bus.ack1, 1); chk("t2_c3_rdata", bus.rdata, 16'h1234);
    bus.req1 = 0;
    tick; chk("t2_ram", ram[9'h01A], 16'hBEEF);
    issue(0, 1'b0, 9'h01A, '0);
    tick; tick; tick;
    chk("t2_rb_ack0", bus.ack0, 1); chk("t2_rb_rdata", bus.rdata, 16'hBEEF);
    bus.req0 = 0;
    tick;

    // Contention after reset, both held: acks alternate 0,1,0,1,0
    do_reset;
    for (int k = 0; k < 3; k++) issue(0, 1'b0, 9'h040, '0);
    for (int k = 0; k < 2; k++) issue(1, 1'b0, 9'h041, '0);
    for (int c = 1; c <= 15; c++) begin
      tick;
      chk($sformatf("t3_c%0d_ack0", c), bus.ack0, (c % 6 == 3));
      chk($sformatf("t3_c%0d_ack1", c), bus.ack1, (c % 6 == 0));
      if (c == 4) chk("t3_c4_addr", bus.mem_addr, 9'h041);
      if (c == 15) begin bus.req0 = 0; bus.req1 = 0; end
    end
    tick; tick; chk("t3_idle", bus.busy, 0);

    // Held request: no re-grant in the ack cycle; next ACCESS at cycle 5
    issue(0, 1'b0, 9'h050, '0);
    push_exp(0, 1'b0, 9'h050, '0);
    for (int c = 1; c <= 7; c++) begin
      tick;
      chk($sformatf("t4_c%0d_busy", c), bus.busy, (c == 1 || c == 2 || c == 5 || c == 6));
      chk($sformatf("t4_c%0d_ack0", c), bus.ack0, (c == 3 || c == 7));
      if (c == 7) bus.req0 = 0;
    end
    tick;

    // Address change during ACCESS is ignored
    issue(0, 1'b0, 9'h010, '0);
    tick; chk("t5_c1_addr", bus.mem_addr, 9'h010); bus.addr0 = 9'h020;
    tick; chk("t5_c2_addr", bus.mem_addr, 9'h010);
    tick; chk("t5_c3_ack0", bus.ack0, 1);
    bus.req0 = 0;
    tick;

    // Reset in DONE of a read abandons it
    issue(0, 1'b0, 9'h030, '0);
    tick; tick;
    chk("t6_c2_cmd", bus.mem_cmd, 2'b01);
    reset = 1'b1; last_rd = '0;
    q0.delete();
    tick;
    reset = 1'b0; bus.req0 = 0;
    chk("t6_ack",   {bus.ack1, bus.ack0}, 0);
    chk("t6_cmd",   bus.mem_cmd, 2'b00);
    chk("t6_busy",  bus.busy, 0);
    chk("t6_rdata", bus.rdata, 0);
    tick;
    issue(0, 1'b0, 9'h060, '0);
    issue(1, 1'b0, 9'h061, '0);
    tick; tick; tick;
    chk("t6_ack0_first", bus.ack0, 1); chk("t6_ack1_first", bus.ack1, 0);
    bus.req0 = 0;
    tick; tick; tick;
    chk("t6_ack1_second", bus.ack1, 1);
    bus.req1 = 0;
    tick; tick;

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
